// File: rtl/save_load_sequencer_if.sv
// rtl/save_load_sequencer_if.sv - processor-side save/load command bus
//
// Purpose: carries one save/load command from the sequencer to the processor
//          and the processor's completion back.
// Signals:
//   cmd_valid  command presented (sequencer -> processor)
//   cmd_ready  processor accepts command (processor -> sequencer)
//   cmd_op     0 = save, 1 = load
//   cmd_slot   command slot index
//   cmd_data   save payload, 0 for load
//   cmd_done   processor completion pulse
//   done_data  loaded snapshot, valid with cmd_done on a load
// Modports: master = sequencer side, slave = processor side.

interface save_load_sequencer_if #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [SLOT_W-1:0] cmd_slot;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_done;
    logic [DATA_W-1:0] done_data;

    modport master (
        output cmd_valid, cmd_op, cmd_slot, cmd_data,
        input  cmd_ready, cmd_done, done_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_slot, cmd_data,
        output cmd_ready, cmd_done, done_data
    );
endinterface

// File: rtl/save_load_sequencer.sv
// rtl/save_load_sequencer.sv - save/load request sequencer onto the processor path
//
// Purpose: captures save (slot + sensor snapshot) and load (slot) requests in
//          one pending entry each, round-robin arbitrates when both are
//          pending, issues one command at a time on the processor bus, waits
//          for completion or timeout, and returns load results.
// Ports:
//   clock, reset             clock, async active-high reset
//   save_req/save_slot/sensor_in  save request pulse, slot, snapshot
//   load_req/load_slot       load request pulse, slot
//   bus                      processor command bus (master modport)
//   load_valid/load_data     1-cycle load result pulse, held result
//   busy                     sequencer not idle
//   err_timeout/err_drop     sticky error flags
//   clr_err                  clears sticky error flags

module save_load_sequencer #(
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  save_req,
    input  logic [SLOT_W-1:0]     save_slot,
    input  logic [DATA_W-1:0]     sensor_in,
    input  logic                  load_req,
    input  logic [SLOT_W-1:0]     load_slot,
    save_load_sequencer_if.master bus,
    output logic                  load_valid,
    output logic [DATA_W-1:0]     load_data,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_drop,
    input  logic                  clr_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_next;
    logic [TW-1:0]     timer;
    logic              rr_load;      // 0: save wins next tie, 1: load wins
    logic              cur_op;       // op of the command in flight
    logic              save_pend, load_pend;
    logic [SLOT_W-1:0] save_slot_q, load_slot_q;
    logic [DATA_W-1:0] save_data_q;

    logic take, pick_load, flip, hs, issue_to, wait_to, done_ok;
    logic save_clr, load_clr, drop_set;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        pick_load  = 1'b0;
        flip       = 1'b0;
        hs         = 1'b0;
        issue_to   = 1'b0;
        wait_to    = 1'b0;
        done_ok    = 1'b0;
        case (state)
            IDLE: begin
                if (save_pend || load_pend) begin
                    take       = 1'b1;
                    state_next = ISSUE;
                    if (save_pend && load_pend) begin
                        pick_load = rr_load;
                        flip      = 1'b1;
                    end else begin
                        pick_load = load_pend;
                    end
                end
            end
            ISSUE: begin
                // Acceptance beats a timeout landing in the same cycle.
                if (bus.cmd_ready) begin
                    hs         = 1'b1;
                    state_next = WAIT;
                end else if (timer == TIMEOUT_T) begin
                    issue_to   = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (bus.cmd_done) begin
                    done_ok    = 1'b1;
                    state_next = IDLE;
                end else if (timer == TIMEOUT_T) begin
                    wait_to    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Entry leaves pending when accepted or abandoned in ISSUE; a request in
    // that same cycle refills it instead of being dropped.
    assign save_clr = (hs || issue_to) && !cur_op;
    assign load_clr = (hs || issue_to) &&  cur_op;
    assign drop_set = (save_req && save_pend && !save_clr) ||
                      (load_req && load_pend && !load_clr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            save_pend   <= 1'b0;
            save_slot_q <= '0;
            save_data_q <= '0;
            load_pend   <= 1'b0;
            load_slot_q <= '0;
        end else begin
            if (save_req && (!save_pend || save_clr)) begin
                save_pend   <= 1'b1;
                save_slot_q <= save_slot;
                save_data_q <= sensor_in;
            end else if (save_clr) begin
                save_pend   <= 1'b0;
            end
            if (load_req && (!load_pend || load_clr)) begin
                load_pend   <= 1'b1;
                load_slot_q <= load_slot;
            end else if (load_clr) begin
                load_pend   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer       <= '0;
            rr_load     <= 1'b0;
            cur_op      <= 1'b0;
            load_valid  <= 1'b0;
            load_data   <= '0;
            err_timeout <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            if (take || hs)          timer <= '0;
            else if (state != IDLE)  timer <= timer + TW'(1);
            if (take)                cur_op  <= pick_load;
            if (flip)                rr_load <= !rr_load;
            load_valid <= done_ok && cur_op;
            if (done_ok && cur_op)   load_data <= bus.done_data;
            // A new error event outranks a simultaneous clear.
            err_timeout <= (issue_to || wait_to) || (err_timeout && !clr_err);
            err_drop    <= drop_set || (err_drop && !clr_err);
        end
    end

    // Payload comes straight from the pending entry, which cannot change
    // while it is being issued because new requests for it are dropped.
    assign bus.cmd_valid = (state == ISSUE);
    assign bus.cmd_op    = (state == ISSUE) && cur_op;
    assign bus.cmd_slot  = (state != ISSUE) ? '0 : (cur_op ? load_slot_q : save_slot_q);
    assign bus.cmd_data  = (state == ISSUE && !cur_op) ? save_data_q : '0;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_save_load_sequencer.sv
// tb/tb_save_load_sequencer.sv - scoreboard bench for save_load_sequencer

module tb_save_load_sequencer;
    localparam int DATA_W = 24;
    localparam int SLOT_W = 3;
    localparam int TIMEOUT = 1023;

    typedef struct packed {
        logic              op;
        logic [SLOT_W-1:0] slot;
        logic [DATA_W-1:0] data;
    } cmd_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              save_req = 1'b0;
    logic [SLOT_W-1:0] save_slot = '0;
    logic [DATA_W-1:0] sensor_in = '0;
    logic              load_req = 1'b0;
    logic [SLOT_W-1:0] load_slot = '0;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              busy, err_timeout, err_drop;
    logic              clr_err = 1'b0;

    save_load_sequencer_if #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) bus ();

    save_load_sequencer #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .save_req(save_req), .save_slot(save_slot), .sensor_in(sensor_in),
        .load_req(load_req), .load_slot(load_slot),
        .bus(bus),
        .load_valid(load_valid), .load_data(load_data),
        .busy(busy), .err_timeout(err_timeout), .err_drop(err_drop),
        .clr_err(clr_err)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    cmd_t              exp_cmd_q[$];
    logic [DATA_W-1:0] exp_load_q[$];

    int                done_delay = 4;   // -1: processor never completes
    logic [DATA_W-1:0] resp_data  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted command and every load result.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {bus.cmd_op, bus.cmd_slot, bus.cmd_data}, 32'hFFFF_FFFF);
                end else begin
                    cmd_t e;
                    e = exp_cmd_q.pop_front();
                    chk("cmd_op",   32'(bus.cmd_op),   32'(e.op));
                    chk("cmd_slot", 32'(bus.cmd_slot), 32'(e.slot));
                    chk("cmd_data", 32'(bus.cmd_data), 32'(e.data));
                end
            end
            if (load_valid) begin
                if (exp_load_q.size() == 0)
                    chk("unexpected_load_valid", 32'(load_data), 32'hFFFF_FFFF);
                else
                    chk("load_data", 32'(load_data), 32'(exp_load_q.pop_front()));
            end
        end
    end

    // Processor model: completes each accepted command done_delay cycles later.
    initial begin
        bus.cmd_ready = 1'b1;
        bus.cmd_done  = 1'b0;
        bus.done_data = '0;
        forever begin
            @(negedge clock);
            if (!reset && bus.cmd_valid && bus.cmd_ready && done_delay >= 0) begin
                int d;
                d = done_delay;
                @(posedge clock);
                repeat (d) @(posedge clock);
                #1;
                bus.cmd_done  = 1'b1;
                bus.done_data = resp_data;
                @(posedge clock);
                #1;
                bus.cmd_done  = 1'b0;
                bus.done_data = '0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic [SLOT_W-1:0] ss, input logic [DATA_W-1:0] sd,
                         input logic l, input logic [SLOT_W-1:0] ls);
        @(posedge clock); #1;
        save_req = s; save_slot = ss; sensor_in = sd;
        load_req = l; load_slot = ls;
        @(posedge clock); #1;
        save_req = 1'b0; load_req = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int q = 0;
        int n = 0;
        while (q < 3 && n < budget) begin
            @(negedge clock);
            n++;
            if (busy) q = 0; else q++;
        end
        chk(name, 32'(q >= 3), 32'd1);
    endtask

    task automatic pulse_clr();
        @(posedge clock); #1;
        clr_err = 1'b1;
        @(posedge clock); #1;
        clr_err = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        chk("rst_cmd_bus", {bus.cmd_op, bus.cmd_slot, bus.cmd_data}, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {load_valid, err_timeout, err_drop}, 0);
        chk("rst_load_data", 32'(load_data), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Single save, two-cycle request-to-valid latency
        exp_cmd_q.push_back('{1'b0, 3'd3, 24'hABCDEF});
        done_delay = 4;
        pulse(1, 3'd3, 24'hABCDEF, 0, 3'd0);
        @(negedge clock);
        chk("lat_valid_c1", 32'(bus.cmd_valid), 0);
        @(negedge clock);
        chk("lat_valid_c2", 32'(bus.cmd_valid), 1);
        chk("save_busy", 32'(busy), 1);
        wait_quiet("save_idle", 50);
        chk("save_no_err", {err_timeout, err_drop}, 0);

        // Simultaneous pairs: save first after reset, then load first
        do_reset();
        resp_data = 24'h0A0B0C;
        exp_cmd_q.push_back('{1'b0, 3'd1, 24'h111111});
        exp_cmd_q.push_back('{1'b1, 3'd2, 24'h0});
        exp_load_q.push_back(24'h0A0B0C);
        pulse(1, 3'd1, 24'h111111, 1, 3'd2);
        wait_quiet("pair1_idle", 100);
        resp_data = 24'h0D0E0F;
        exp_cmd_q.push_back('{1'b1, 3'd6, 24'h0});
        exp_cmd_q.push_back('{1'b0, 3'd4, 24'h222222});
        exp_load_q.push_back(24'h0D0E0F);
        pulse(1, 3'd4, 24'h222222, 1, 3'd6);
        wait_quiet("pair2_idle", 100);
        // Second pair finished with a save, so the load result must be held
        chk("pair2_load_held", 32'(load_data), 32'h0D0E0F);

        // Load slot 5
        resp_data = 24'h123456;
        exp_cmd_q.push_back('{1'b1, 3'd5, 24'h0});
        exp_load_q.push_back(24'h123456);
        pulse(0, 3'd0, 24'h0, 1, 3'd5);
        wait_quiet("load_idle", 50);
        chk("load_data_held", 32'(load_data), 32'h123456);

        // Drops while stalled
        bus.cmd_ready = 1'b0;
        exp_cmd_q.push_back('{1'b0, 3'd7, 24'h00C0DE});
        pulse(1, 3'd7, 24'h00C0DE, 0, 3'd0);
        pulse(1, 3'd2, 24'h999999, 0, 3'd0);
        pulse(1, 3'd3, 24'h888888, 0, 3'd0);
        @(negedge clock);
        chk("drop_err", 32'(err_drop), 1);
        chk("drop_stalled_valid", 32'(bus.cmd_valid), 1);
        chk("drop_stalled_data", 32'(bus.cmd_data), 32'h00C0DE);
        @(posedge clock); #1;
        bus.cmd_ready = 1'b1;
        wait_quiet("drop_idle", 50);
        chk("drop_err_sticky", 32'(err_drop), 1);
        pulse_clr();
        @(negedge clock);
        chk("drop_err_clr", 32'(err_drop), 0);

        // Load never completes -> timeout
        done_delay = -1;
        exp_cmd_q.push_back('{1'b1, 3'd0, 24'h0});
        pulse(0, 3'd0, 24'h0, 1, 3'd0);
        repeat (1000) @(negedge clock);
        chk("to_busy_early", 32'(busy), 1);
        chk("to_err_early", 32'(err_timeout), 0);
        wait_quiet("to_idle", 200);
        chk("to_err", 32'(err_timeout), 1);
        pulse_clr();
        @(negedge clock);
        chk("to_err_clr", 32'(err_timeout), 0);

        // Reset while in WAIT with a load still pending
        exp_cmd_q.push_back('{1'b0, 3'd1, 24'h5A5A5A});
        pulse(1, 3'd1, 24'h5A5A5A, 1, 3'd4);
        repeat (4) @(posedge clock);
        #1;
        chk("wr_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("wr_outputs", {busy, bus.cmd_valid, load_valid, err_timeout, err_drop}, 0);
        chk("wr_load_data", 32'(load_data), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("wr_pending_cleared", 32'(busy), 0);

        chk("cmd_q_empty", 32'(exp_cmd_q.size()), 0);
        chk("load_q_empty", 32'(exp_load_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
